// File: rtl/alu_issue_pkg.sv
// Shared widths, ALU op encodings and the decoded-instruction request struct
// for the operand-issue stage.
package alu_issue_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int OS_W   = 3;
    localparam int NUM_SRC = 2;

    typedef enum logic [OS_W-1:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
        OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_OP7 = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [OS_W-1:0]   os;
        logic              use_imm;
        logic [DATA_W-1:0] imm;
    } issue_req_t;
endpackage

// File: rtl/alu_issue_if.sv
// Decoded-instruction handshake into the issue stage.
interface alu_issue_if;
    import alu_issue_pkg::*;
    logic       valid;
    logic       ready;
    issue_req_t req;

    modport master (output valid, output req, input ready);
    modport slave  (input valid, input req, output ready);
endinterface

// File: rtl/alu_issue_fwd_mux.sv
// Per-source operand bypass: x0, then ALU result, then writeback, then regfile.
module alu_fwd_mux
    import alu_issue_pkg::*;
(
    input  logic [REG_AW-1:0] src_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              ex_valid_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [DATA_W-1:0] alu_rd_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] data_o
);
    always_comb begin
        data_o = rf_data_i;
        if (src_i == '0)
            data_o = '0;
        else if (ex_valid_i && ex_rd_i == src_i)
            data_o = alu_rd_i;
        else if (wb_we_i && wb_addr_i == src_i)
            data_o = wb_data_i;
    end
endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage: bypassed operand resolution, one-cycle ALU hazard stall,
// registered sr1/sr2/os/shift and in-flight destination tracking.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    alu_issue_if.slave        in_if,
    input  logic              flush_i,
    output logic [REG_AW-1:0] rf_ra1_o,
    output logic [REG_AW-1:0] rf_ra2_o,
    input  logic [DATA_W-1:0] rf_rd1_i,
    input  logic [DATA_W-1:0] rf_rd2_i,
    input  logic [DATA_W-1:0] alu_rd_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] sr1_o,
    output logic [DATA_W-1:0] sr2_o,
    output logic [OS_W-1:0]   os_o,
    output logic [DATA_W-1:0] shift_o,
    output logic              iss_valid_o,
    output logic              ex_valid_o,
    output logic [REG_AW-1:0] ex_rd_addr_o
);
    logic [DATA_W-1:0] sr1_q, sr1_d, sr2_q, sr2_d, shift_q, shift_d;
    logic [OS_W-1:0]   os_q, os_d;
    logic [REG_AW-1:0] iss_rd_q, iss_rd_d, ex_rd_q;
    logic              iss_valid_q, ex_valid_q;

    logic [NUM_SRC-1:0][REG_AW-1:0] src;
    logic [NUM_SRC-1:0][DATA_W-1:0] rf_data, fwd_data;
    logic [DATA_W-1:0]              op2;
    logic                           stall, accept;

    assign rf_ra1_o   = in_if.req.rs1;
    assign rf_ra2_o   = in_if.req.rs2;
    assign src        = {in_if.req.rs2, in_if.req.rs1};
    assign rf_data    = {rf_rd2_i, rf_rd1_i};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        alu_fwd_mux u_fwd (
            .src_i      (src[g]),
            .rf_data_i  (rf_data[g]),
            .ex_valid_i (ex_valid_q),
            .ex_rd_i    (ex_rd_q),
            .alu_rd_i   (alu_rd_i),
            .wb_we_i    (wb_we_i),
            .wb_addr_i  (wb_addr_i),
            .wb_data_i  (wb_data_i),
            .data_o     (fwd_data[g])
        );
    end

    // The issued result only reaches alu_rd a cycle later; a consumer right
    // behind its producer waits one bubble and then picks it off the bypass.
    assign stall = in_if.valid && iss_valid_q && (iss_rd_q != '0) &&
                   ((iss_rd_q == in_if.req.rs1) ||
                    (!in_if.req.use_imm && iss_rd_q == in_if.req.rs2));
    assign in_if.ready = ~stall;
    assign accept      = in_if.valid && !stall && !flush_i;
    assign op2         = in_if.req.use_imm ? in_if.req.imm : fwd_data[1];

    always_comb begin
        sr1_d    = sr1_q;
        sr2_d    = sr2_q;
        os_d     = os_q;
        shift_d  = shift_q;
        iss_rd_d = iss_rd_q;
        if (accept) begin
            sr1_d    = fwd_data[0];
            sr2_d    = op2;
            os_d     = in_if.req.os;
            shift_d  = {{(DATA_W-5){1'b0}}, op2[4:0]};
            iss_rd_d = in_if.req.rd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr1_q       <= '0;
            sr2_q       <= '0;
            os_q        <= '0;
            shift_q     <= '0;
            iss_rd_q    <= '0;
            ex_rd_q     <= '0;
            iss_valid_q <= 1'b0;
            ex_valid_q  <= 1'b0;
        end else begin
            sr1_q       <= sr1_d;
            sr2_q       <= sr2_d;
            os_q        <= os_d;
            shift_q     <= shift_d;
            iss_rd_q    <= iss_rd_d;
            ex_rd_q     <= iss_rd_q;
            iss_valid_q <= accept;
            ex_valid_q  <= iss_valid_q && !flush_i;
        end
    end

    assign sr1_o        = sr1_q;
    assign sr2_o        = sr2_q;
    assign os_o         = os_q;
    assign shift_o      = shift_q;
    assign iss_valid_o  = iss_valid_q;
    assign ex_valid_o   = ex_valid_q;
    assign ex_rd_addr_o = ex_rd_q;
endmodule
